// File: rtl/fdiv16.sv
// fdiv16: multi-cycle fp16 divider with a valid/ready handshake on both sides.
// Zero and subnormal inputs are treated as signed zero and results never go
// subnormal. Specials resolve at acceptance. Finite operands run a 14-step
// restoring mantissa division, one rounding cycle, then hold in DONE until
// the consumer takes the result.
module fdiv16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [1:0]  roundmode,
  input  logic        negr,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] result,
  output logic [4:0]  flags,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int unsigned MW = 11;  // mantissa width including hidden bit
  localparam int unsigned QW = 14;  // quotient bits produced
  localparam int unsigned RW = 12;  // partial remainder width
  localparam int unsigned EW = 7;   // signed working exponent width
  localparam int unsigned CW = 4;   // division step counter width

  localparam logic [1:0] RM_RZ  = 2'b00;
  localparam logic [1:0] RM_RNE = 2'b01;
  localparam logic [1:0] RM_RP  = 2'b10;
  localparam logic [1:0] RM_RN  = 2'b11;

  localparam logic [CW-1:0] LAST_STEP = CW'(QW - 1);

  // Flag bit positions in {invalid, divzero, overflow, underflow, inexact}
  localparam logic [4:0] FLG_INVALID = 5'b10000;
  localparam logic [4:0] FLG_DIVZERO = 5'b01000;
  localparam logic [4:0] FLG_OVF     = 5'b00101;
  localparam logic [4:0] FLG_UNF     = 5'b00011;

  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [14:0] INF_MAG = 15'h7C00;
  localparam logic [14:0] MAX_MAG = 15'h7BFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    ROUND  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_nx;

  // Operation registers captured at acceptance
  logic                 sign_q;
  logic [1:0]           rm_q;
  logic signed [EW-1:0] exp_q;
  logic [MW-1:0]        dvs_q;
  logic [RW-1:0]        rem_q;
  logic [QW-1:0]        quo_q;
  logic [CW-1:0]        cnt_q;

  // Acceptance and operand classification
  logic        accept_c;
  logic        sign_c;
  logic        x_zero_c, x_inf_c, x_nan_c;
  logic        y_zero_c, y_inf_c, y_nan_c;
  logic        special_c;
  logic [15:0] spec_res_c;
  logic [4:0]  spec_flg_c;

  // Division step
  logic          ge_c;
  logic [RW-1:0] rem_sub_c;

  // Normalisation and rounding
  logic                 rem_nz_c;
  logic [MW-1:0]        mant_c;
  logic                 guard_c;
  logic                 sticky_c;
  logic signed [EW-1:0] exp_c;
  logic                 inc_c;
  logic [MW:0]          mant_sum_c;
  logic [MW-1:0]        mant_r_c;
  logic signed [EW-1:0] exp_r_c;
  logic                 max_fin_c;
  logic [15:0]          rnd_res_c;
  logic [4:0]           rnd_flg_c;

  assign accept_c = in_valid & in_ready;

  // Classify operands and form the early result for special cases
  always_comb begin
    sign_c     = x[15] ^ y[15] ^ negr;
    x_zero_c   = (x[14:10] == 5'd0);
    x_inf_c    = (x[14:10] == 5'h1F) && (x[9:0] == 10'd0);
    x_nan_c    = (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
    y_zero_c   = (y[14:10] == 5'd0);
    y_inf_c    = (y[14:10] == 5'h1F) && (y[9:0] == 10'd0);
    y_nan_c    = (y[14:10] == 5'h1F) && (y[9:0] != 10'd0);
    special_c  = x_zero_c | x_inf_c | x_nan_c | y_zero_c | y_inf_c | y_nan_c;
    spec_res_c = {sign_c, 15'd0};
    spec_flg_c = 5'd0;
    if (x_nan_c || y_nan_c || (x_zero_c && y_zero_c) || (x_inf_c && y_inf_c)) begin
      spec_res_c = QNAN;
      spec_flg_c = FLG_INVALID;
    end else if (x_inf_c) begin
      spec_res_c = {sign_c, INF_MAG};
    end else if (y_zero_c) begin
      spec_res_c = {sign_c, INF_MAG};
      spec_flg_c = FLG_DIVZERO;
    end
  end

  // One restoring step: subtract the divisor when it fits
  always_comb begin
    ge_c      = (rem_q >= RW'(dvs_q));
    rem_sub_c = rem_q;
    if (ge_c) begin
      rem_sub_c = rem_q - RW'(dvs_q);
    end
  end

  // Normalise the quotient, round, and detect exponent range faults
  always_comb begin
    rem_nz_c = (rem_q != RW'(0));
    if (quo_q[QW-1]) begin
      mant_c   = quo_q[13:3];
      guard_c  = quo_q[2];
      sticky_c = (|quo_q[1:0]) | rem_nz_c;
      exp_c    = exp_q + 7'sd15;
    end else begin
      mant_c   = quo_q[12:2];
      guard_c  = quo_q[1];
      sticky_c = quo_q[0] | rem_nz_c;
      exp_c    = exp_q + 7'sd14;
    end

    inc_c = 1'b0;
    case (rm_q)
      RM_RZ:   inc_c = 1'b0;
      RM_RNE:  inc_c = guard_c & (sticky_c | mant_c[0]);
      RM_RP:   inc_c = (guard_c | sticky_c) & ~sign_q;
      RM_RN:   inc_c = (guard_c | sticky_c) & sign_q;
      default: inc_c = 1'b0;
    endcase

    mant_sum_c = {1'b0, mant_c} + (MW+1)'(inc_c);
    if (mant_sum_c[MW]) begin
      mant_r_c = 11'h400;
      exp_r_c  = exp_c + 7'sd1;
    end else begin
      mant_r_c = mant_sum_c[MW-1:0];
      exp_r_c  = exp_c;
    end

    // Directed modes that round toward zero on overflow saturate to max finite
    max_fin_c = (rm_q == RM_RZ) || ((rm_q == RM_RP) && sign_q) ||
                ((rm_q == RM_RN) && !sign_q);

    rnd_res_c = {sign_q, exp_r_c[4:0], mant_r_c[9:0]};
    rnd_flg_c = {4'd0, guard_c | sticky_c};
    if (exp_r_c >= 7'sd31) begin
      rnd_res_c = max_fin_c ? {sign_q, MAX_MAG} : {sign_q, INF_MAG};
      rnd_flg_c = FLG_OVF;
    end else if (exp_r_c <= 7'sd0) begin
      rnd_res_c = {sign_q, 15'd0};
      rnd_flg_c = FLG_UNF;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept_c) state_nx = special_c ? DONE : DIVIDE;
      DIVIDE:  if (cnt_q == CW'(0)) state_nx = ROUND;
      ROUND:   state_nx = DONE;
      DONE:    if (out_valid && out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= 16'd0;
      flags     <= 5'd0;
      sign_q    <= 1'b0;
      rm_q      <= 2'd0;
      exp_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
    end else begin
      in_ready  <= (state_nx == IDLE);
      out_valid <= (state == DONE) && !(out_valid && out_ready);
      case (state)
        IDLE: begin
          if (accept_c) begin
            sign_q <= sign_c;
            rm_q   <= roundmode;
            exp_q  <= $signed(EW'({2'b00, x[14:10]})) - $signed(EW'({2'b00, y[14:10]}));
            dvs_q  <= {1'b1, y[9:0]};
            rem_q  <= RW'({1'b1, x[9:0]});
            quo_q  <= '0;
            cnt_q  <= LAST_STEP;
            if (special_c) begin
              result <= spec_res_c;
              flags  <= spec_flg_c;
            end
          end
        end
        DIVIDE: begin
          quo_q <= {quo_q[QW-2:0], ge_c};
          rem_q <= rem_sub_c << 1;
          cnt_q <= cnt_q - CW'(1);
        end
        ROUND: begin
          result <= rnd_res_c;
          flags  <= rnd_flg_c;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fdiv16.sv
// Scoreboard bench for fdiv16: expectations are queued when an operation is
// issued and compared when the divider presents its result.
module tb_fdiv16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] x, y;
  logic [1:0]  roundmode;
  logic        negr;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] result;
  logic [4:0]  flags;
  logic        out_valid;
  logic        out_ready;

  fdiv16 dut (
    .clk       (clk),
    .reset     (reset),
    .x         (x),
    .y         (y),
    .roundmode (roundmode),
    .negr      (negr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .flags     (flags),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic [4:0]  flg;
    int          lat;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  rm;
    logic        ng;
    logic [15:0] res;
    logic [4:0]  flg;
    int          lat;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: integer long division, then normalise/round/range check
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic [1:0] rm, input logic ng);
    exp_t e;
    int ea, eb, fa, fb, s;
    int num, q, r, mant, g, st, ex, inc;
    bit az, ai, an, bz, bi, bn;
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    fa = int'(a[9:0]);   fb = int'(b[9:0]);
    az = (ea == 0); ai = (ea == 31 && fa == 0); an = (ea == 31 && fa != 0);
    bz = (eb == 0); bi = (eb == 31 && fb == 0); bn = (eb == 31 && fb != 0);
    s  = (a[15] ^ b[15] ^ ng) ? 1 : 0;
    e.lat = 1;
    e.flg = 5'd0;
    if (an || bn || (az && bz) || (ai && bi)) begin
      e.res = 16'h7E00; e.flg = 5'b10000; return e;
    end
    if (ai) begin e.res = {s[0], 15'h7C00}; return e; end
    if (bz) begin e.res = {s[0], 15'h7C00}; e.flg = 5'b01000; return e; end
    if (az || bi) begin e.res = {s[0], 15'h0000}; return e; end
    e.lat = 16;
    num = (1024 + fa) << 13;
    q   = num / (1024 + fb);
    r   = num % (1024 + fb);
    if (q >= 8192) begin
      mant = q >> 3; g = (q >> 2) & 1; st = ((q & 3) != 0 || r != 0) ? 1 : 0; ex = ea - eb + 15;
    end else begin
      mant = q >> 2; g = (q >> 1) & 1; st = ((q & 1) != 0 || r != 0) ? 1 : 0; ex = ea - eb + 14;
    end
    case (rm)
      2'd0:    inc = 0;
      2'd1:    inc = (g != 0 && (st != 0 || (mant & 1) != 0)) ? 1 : 0;
      2'd2:    inc = ((g | st) != 0 && s == 0) ? 1 : 0;
      default: inc = ((g | st) != 0 && s == 1) ? 1 : 0;
    endcase
    mant = mant + inc;
    if (mant == 2048) begin mant = 1024; ex = ex + 1; end
    if (ex >= 31) begin
      e.flg = 5'b00101;
      if (rm == 2'd0 || (rm == 2'd2 && s == 1) || (rm == 2'd3 && s == 0))
        e.res = {s[0], 15'h7BFF};
      else
        e.res = {s[0], 15'h7C00};
    end else if (ex <= 0) begin
      e.flg = 5'b00011;
      e.res = {s[0], 15'h0000};
    end else begin
      e.flg = {4'd0, (g | st) != 0};
      e.res = {s[0], 5'(ex), 10'(mant)};
    end
    return e;
  endfunction

  // Wait for IDLE, present one operation, queue its expectation, then scramble inputs
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [1:0] rm,
                       input logic ng, input exp_t e);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    sb.push_back(e);
    x = a; y = b; roundmode = rm; negr = ng; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    x         = 16'($urandom);
    y         = 16'($urandom);
    roundmode = 2'($urandom);
    negr      = 1'($urandom);
  endtask

  // Take the result off the output port
  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  // Count edges from acceptance until out_valid (bounded); lat=-1 on timeout
  task automatic collect(input bit do_ack, output int lat,
                         output logic [15:0] r, output logic [4:0] f);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    r = result;
    f = flags;
    if (do_ack && lat > 0) ack();
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x = 16'd0; y = 16'd0; roundmode = 2'd0; negr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 16'h0000 || flags !== 5'd0) begin
      n_errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h flags=%b, expected 1 0 0000 00000",
               in_ready, out_valid, result, flags);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_spec_vectors();
    vec_t v[$];
    exp_t e, g;
    int lat;
    logic [15:0] r;
    logic [4:0] f;
    v.push_back('{16'h3C00, 16'h3C00, 2'd1, 1'b0, 16'h3C00, 5'b00000, 16});
    v.push_back('{16'h3C00, 16'h4200, 2'd1, 1'b0, 16'h3555, 5'b00001, 16});
    v.push_back('{16'h3C00, 16'h4200, 2'd2, 1'b0, 16'h3556, 5'b00001, 16});
    v.push_back('{16'h3C00, 16'h4200, 2'd0, 1'b0, 16'h3555, 5'b00001, 16});
    v.push_back('{16'h4600, 16'h4000, 2'd1, 1'b0, 16'h4200, 5'b00000, 16});
    v.push_back('{16'h4600, 16'h4000, 2'd1, 1'b1, 16'hC200, 5'b00000, 16});
    v.push_back('{16'h7BFF, 16'h1400, 2'd1, 1'b0, 16'h7C00, 5'b00101, 16});
    v.push_back('{16'h7BFF, 16'h1400, 2'd0, 1'b0, 16'h7BFF, 5'b00101, 16});
    v.push_back('{16'hBC00, 16'h4200, 2'd3, 1'b0, 16'hB556, 5'b00001, 16});
    v.push_back('{16'hBC00, 16'h4200, 2'd2, 1'b0, 16'hB555, 5'b00001, 16});
    v.push_back('{16'hFBFF, 16'h1400, 2'd2, 1'b0, 16'hFBFF, 5'b00101, 16});
    v.push_back('{16'hFBFF, 16'h1400, 2'd3, 1'b0, 16'hFC00, 5'b00101, 16});
    v.push_back('{16'h0400, 16'h7800, 2'd1, 1'b0, 16'h0000, 5'b00011, 16});
    foreach (v[i]) begin
      e = '{v[i].res, v[i].flg, v[i].lat};
      issue(v[i].a, v[i].b, v[i].rm, v[i].ng, e);
      collect(1'b1, lat, r, f);
      g = sb.pop_front();
      n_checks++;
      if (r !== g.res || f !== g.flg || lat != g.lat) begin
        n_errors++;
        $display("FAIL vector_%0d (%h/%h rm=%0d negr=%b): got res=%h flg=%b lat=%0d, expected res=%h flg=%b lat=%0d",
                 i, v[i].a, v[i].b, v[i].rm, v[i].ng, r, f, lat, g.res, g.flg, g.lat);
      end
    end
  endtask

  task automatic test_special();
    vec_t v[$];
    exp_t e, g;
    int lat;
    logic [15:0] r;
    logic [4:0] f;
    v.push_back('{16'h3C00, 16'h0000, 2'd1, 1'b0, 16'h7C00, 5'b01000, 1});
    v.push_back('{16'h0000, 16'h0000, 2'd1, 1'b0, 16'h7E00, 5'b10000, 1});
    v.push_back('{16'h7C00, 16'h4000, 2'd1, 1'b0, 16'h7C00, 5'b00000, 1});
    v.push_back('{16'hBC00, 16'h7C00, 2'd1, 1'b0, 16'h8000, 5'b00000, 1});
    v.push_back('{16'h7E01, 16'h3C00, 2'd1, 1'b1, 16'h7E00, 5'b10000, 1});
    v.push_back('{16'h7C00, 16'hFC00, 2'd0, 1'b0, 16'h7E00, 5'b10000, 1});
    v.push_back('{16'h0001, 16'h3C00, 2'd1, 1'b0, 16'h0000, 5'b00000, 1});
    v.push_back('{16'h7C00, 16'h8000, 2'd1, 1'b0, 16'hFC00, 5'b00000, 1});
    v.push_back('{16'hC000, 16'h83FF, 2'd1, 1'b1, 16'hFC00, 5'b01000, 1});
    foreach (v[i]) begin
      e = '{v[i].res, v[i].flg, v[i].lat};
      issue(v[i].a, v[i].b, v[i].rm, v[i].ng, e);
      collect(1'b1, lat, r, f);
      g = sb.pop_front();
      n_checks++;
      if (r !== g.res || f !== g.flg || lat != g.lat) begin
        n_errors++;
        $display("FAIL special_%0d (%h/%h): got res=%h flg=%b lat=%0d, expected res=%h flg=%b lat=%0d",
                 i, v[i].a, v[i].b, r, f, lat, g.res, g.flg, g.lat);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b, r;
    logic [1:0] rm;
    logic ng;
    logic [4:0] f;
    exp_t g;
    int lat;
    for (int i = 0; i < 60; i++) begin
      a = {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
      b = {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
      if ($urandom_range(0, 9) == 0) a[14:10] = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'd31;
      if ($urandom_range(0, 9) == 0) b[14:10] = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'd31;
      rm = 2'($urandom);
      ng = 1'($urandom);
      issue(a, b, rm, ng, model(a, b, rm, ng));
      collect(1'b1, lat, r, f);
      g = sb.pop_front();
      n_checks++;
      if (r !== g.res || f !== g.flg || lat != g.lat) begin
        n_errors++;
        $display("FAIL random_%0d (%h/%h rm=%0d negr=%b): got res=%h flg=%b lat=%0d, expected res=%h flg=%b lat=%0d",
                 i, a, b, rm, ng, r, f, lat, g.res, g.flg, g.lat);
      end
    end
  endtask

  // Second operand waits on in_valid through the first one's DONE phase
  task automatic test_back_to_back();
    exp_t g;
    int lat;
    logic [15:0] r;
    logic [4:0] f;
    @(negedge clk);
    sb.push_back(model(16'h4600, 16'h4000, 2'd1, 1'b0));
    x = 16'h4600; y = 16'h4000; roundmode = 2'd1; negr = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back(model(16'h3C00, 16'h4200, 2'd2, 1'b1));
    x = 16'h3C00; y = 16'h4200; roundmode = 2'd2; negr = 1'b1;
    collect(1'b0, lat, r, f);
    g = sb.pop_front();
    n_checks++;
    if (r !== g.res || f !== g.flg || lat != g.lat || in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_first: got res=%h flg=%b lat=%0d in_ready=%b, expected res=%h flg=%b lat=%0d in_ready=0",
               r, f, lat, in_ready, g.res, g.flg, g.lat);
    end
    ack();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_idle_after_ack: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x = 16'hFFFF; y = 16'h0000;
    collect(1'b1, lat, r, f);
    g = sb.pop_front();
    n_checks++;
    if (r !== g.res || f !== g.flg || lat != g.lat) begin
      n_errors++;
      $display("FAIL b2b_second: got res=%h flg=%b lat=%0d, expected res=%h flg=%b lat=%0d",
               r, f, lat, g.res, g.flg, g.lat);
    end
  endtask

  // Hold the result under backpressure, then abort a later operation with reset
  task automatic test_backpressure_reset();
    exp_t g;
    int lat, seen;
    logic [15:0] r;
    logic [4:0] f;
    issue(16'h3C00, 16'h4200, 2'd1, 1'b0, '{16'h3555, 5'b00001, 16});
    collect(1'b0, lat, r, f);
    g = sb.pop_front();
    n_checks++;
    if (r !== g.res || f !== g.flg || lat != g.lat) begin
      n_errors++;
      $display("FAIL hold_first: got res=%h flg=%b lat=%0d, expected res=%h flg=%b lat=%0d",
               r, f, lat, g.res, g.flg, g.lat);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || result !== g.res || flags !== g.flg || in_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL hold_cycle_%0d: out_valid=%b result=%h flags=%b in_ready=%b, expected 1 %h %b 0",
                 i, out_valid, result, flags, in_ready, g.res, g.flg);
      end
    end
    ack();

    issue(16'h4600, 16'h4000, 2'd1, 1'b0, '{16'h4200, 5'b00000, 16});
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    void'(sb.pop_back());
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 16'h0000 || flags !== 5'd0) begin
      n_errors++;
      $display("FAIL reset_mid_divide: out_valid=%b in_ready=%b result=%h flags=%b, expected 0 1 0000 00000",
               out_valid, in_ready, result, flags);
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_errors++;
      $display("FAIL aborted_no_output: out_valid seen %0d cycles, expected 0", seen);
    end

    issue(16'h7BFF, 16'h1400, 2'd0, 1'b1, '{16'hFBFF, 5'b00101, 16});
    collect(1'b1, lat, r, f);
    g = sb.pop_front();
    n_checks++;
    if (r !== g.res || f !== g.flg || lat != g.lat) begin
      n_errors++;
      $display("FAIL after_reset_op: got res=%h flg=%b lat=%0d, expected res=%h flg=%b lat=%0d",
               r, f, lat, g.res, g.flg, g.lat);
    end
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_special();
    test_back_to_back();
    test_backpressure_reset();
    test_random();
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
